// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : arb_pkg                                                         |
// | Purpose  : Shared widths, grant-FSM state encoding and access-owner type   |
// |            for the unified-memory arbiter.                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package arb_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    D_ISSUE  = 3'd1,
    F_ISSUE0 = 3'd2,
    F_ISSUE1 = 3'd3,
    WAIT     = 3'd4,
    DONE     = 3'd5
  } arb_state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_F = 1'b1
  } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: mem_arbiter_if                                                  |
// | Purpose  : Bundles the fetch port, data port and memory port of the        |
// |            arbiter.                                                        |
// | Ports    : i_req/i_addr -> i_ack/i_instr       (instruction fetch)         |
// |            d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata  (data load/store)   |
// |            mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata  (byte memory)    |
// |            busy                                 (arbiter not idle)         |
// | Modports : slave  - arbiter view                                           |
// |            master - processor + memory view                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if;

  logic                        i_req;
  logic [arb_pkg::ADDR_W-1:0]  i_addr;
  logic                        i_ack;
  logic [arb_pkg::INSTR_W-1:0] i_instr;

  logic                        d_req;
  logic                        d_we;
  logic [arb_pkg::ADDR_W-1:0]  d_addr;
  logic [arb_pkg::DATA_W-1:0]  d_wdata;
  logic                        d_ack;
  logic [arb_pkg::DATA_W-1:0]  d_rdata;

  logic                        mem_en;
  logic                        mem_we;
  logic [arb_pkg::ADDR_W-1:0]  mem_addr;
  logic [arb_pkg::DATA_W-1:0]  mem_wdata;
  logic [arb_pkg::DATA_W-1:0]  mem_rdata;

  logic                        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_instr, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_instr, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_wait_timer                                                  |
// | Purpose  : Loadable down-counter timing the memory read latency.           |
// | Ports    : clk, reset (async, active-high)                                 |
// |            load/load_val - preset the count                                |
// |            dec           - count down by one (stops at zero)               |
// |            done          - count has reached zero                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_wait_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                     |
// | Purpose  : Shares one byte-wide single-port memory between a 16-bit        |
// |            instruction fetch port and an 8-bit data port. Data has         |
// |            priority; each instruction is built from two byte reads         |
// |            {mem[a], mem[a+1]}.                                             |
// | Ports    : clk, reset (async, active-high), bus (mem_arbiter_if.slave)     |
// | Params   : MEM_LAT      - memory read latency, 1..7 cycles                 |
// |            STARVE_LIMIT - data grants tolerated with fetch pending         |
// | Macro    : ARB_STARVE_GUARD_EN - enables the fetch starvation guard        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  if ((MEM_LAT < 1) || (MEM_LAT > 7)) begin : g_bad_mem_lat
    $error("mem_arbiter: MEM_LAT must be in 1..7");
  end
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 7)) begin : g_bad_starve_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..7");
  end

  // The timer is preset to MEM_LAT-1 so that WAIT lasts exactly MEM_LAT cycles.
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                second_q, second_d;   // fetch: high byte already captured

  logic                tmr_load;
  logic                tmr_done;
  logic                force_f;
  logic                grant_d;
  logic                grant_f;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;

  assign force_f = (starve_q == 3'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (grant_f) begin
      starve_d = '0;
    end else if (grant_d && bus.i_req) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_f = 1'b0;
`endif

  // Grants are only made from IDLE; a pending fetch overrides data once forced.
  assign grant_d = (state_q == IDLE) && bus.d_req && !(force_f && bus.i_req);
  assign grant_f = (state_q == IDLE) && bus.i_req && !grant_d;

  mem_wait_timer #(
    .CNT_W (3)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (LAT_LOAD),
    .dec      (state_q == WAIT),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    hi_d     = hi_q;
    rdata_d  = rdata_q;
    instr_d  = instr_q;
    second_d = second_q;
    tmr_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d = OWN_D;
          addr_d  = bus.d_addr;
          we_d    = bus.d_we;
          wdata_d = bus.d_wdata;
          state_d = D_ISSUE;
        end else if (grant_f) begin
          owner_d  = OWN_F;
          addr_d   = bus.i_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          second_d = 1'b0;
          state_d  = F_ISSUE0;
        end
      end
      D_ISSUE: begin
        tmr_load = !we_q;
        state_d  = we_q ? DONE : WAIT;
      end
      F_ISSUE0: begin
        tmr_load = 1'b1;
        state_d  = WAIT;
      end
      F_ISSUE1: begin
        tmr_load = 1'b1;
        second_d = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (tmr_done) begin
          if (owner_q == OWN_D) begin
            rdata_d = bus.mem_rdata;
            state_d = DONE;
          end else if (!second_q) begin
            hi_d    = bus.mem_rdata;
            state_d = F_ISSUE1;
          end else begin
            instr_d = {hi_q, bus.mem_rdata};
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_D;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      hi_q     <= '0;
      rdata_q  <= '0;
      instr_q  <= '0;
      second_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      hi_q     <= hi_d;
      rdata_q  <= rdata_d;
      instr_q  <= instr_d;
      second_q <= second_d;
    end
  end

  // Memory-side outputs are decoded from the state so they are zero outside
  // the issue cycles and vanish as soon as reset forces IDLE.
  logic issue_d, issue_f0, issue_f1;
  assign issue_d  = (state_q == D_ISSUE);
  assign issue_f0 = (state_q == F_ISSUE0);
  assign issue_f1 = (state_q == F_ISSUE1);

  assign bus.mem_en    = issue_d || issue_f0 || issue_f1;
  assign bus.mem_we    = issue_d && we_q;
  assign bus.mem_addr  = (issue_d || issue_f0) ? addr_q :
                         issue_f1              ? (addr_q + 16'd1) : '0;
  assign bus.mem_wdata = (issue_d && we_q) ? wdata_q : '0;

  assign bus.d_ack   = (state_q == DONE) && (owner_q == OWN_D);
  assign bus.i_ack   = (state_q == DONE) && (owner_q == OWN_F);
  assign bus.d_rdata = rdata_q;
  assign bus.i_instr = instr_q;
  assign bus.busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                  |
// | Purpose  : Self-checking bench for mem_arbiter with a behavioural byte     |
// |            memory of latency LAT and ack-driven scoreboards.               |
// | Macro    : ARB_STARVE_GUARD_EN selects the expected starvation behaviour.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int LAT   = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(
    .MEM_LAT      (LAT),
    .STARVE_LIMIT (LIMIT)
  ) u_dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // ---------------- behavioural memory ----------------
  logic [7:0]  mem     [0:65535];
  logic [7:0]  rd_pipe [0:LAT-1];
  logic        poke_en;
  logic [15:0] poke_addr;
  logic [7:0]  poke_data;

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 8'h00;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.mem_rdata = rd_pipe[LAT-1];

  // ---------------- checking ----------------
  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboards / monitor ----------------
  logic [7:0]  exp_d_q [$];
  logic [15:0] exp_i_q [$];
  logic [15:0] addr_log [$];

  always @(negedge clk) begin
    if (bus.mem_en) addr_log.push_back(bus.mem_addr);
    if (bus.d_ack) begin
      if (exp_d_q.size() == 0) chk("d_ack_unexpected", 1, 0);
      else                     chk("d_rdata", bus.d_rdata, exp_d_q.pop_front());
    end
    if (bus.i_ack) begin
      if (exp_i_q.size() == 0) chk("i_ack_unexpected", 1, 0);
      else                     chk("i_instr", bus.i_instr, exp_i_q.pop_front());
    end
  end

  // ---------------- helpers ----------------
  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    poke_en = 1'b1; poke_addr = a; poke_data = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Steps cycles until the selected ack is seen; cyc returns the cycle number.
  task automatic wait_ack(input bit is_d, input int start, input int max, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = start;
    while (!seen && (cyc < start + max)) begin
      @(posedge clk); #1;
      cyc++;
      seen = is_d ? bus.d_ack : bus.i_ack;
    end
    if (!seen) chk(is_d ? "d_ack_timeout" : "i_ack_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, d_at, i_at, busy_bad, d_before, d_total, i_seen;
    bit stop;

    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    bus.busy,    0);
    chk("rst_mem_en",  bus.mem_en,  0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_acks",    {bus.i_ack, bus.d_ack}, 0);
    chk("rst_instr",   bus.i_instr, 0);
    chk("rst_rdata",   bus.d_rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- store 0xA5 -> 0x1234 ----
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h1234; bus.d_wdata = 8'hA5;
    exp_d_q.push_back(8'h00);
    @(posedge clk); #1;
    chk("st_mem_en",    bus.mem_en,    1);
    chk("st_mem_we",    bus.mem_we,    1);
    chk("st_mem_addr",  bus.mem_addr,  16'h1234);
    chk("st_mem_wdata", bus.mem_wdata, 8'hA5);
    wait_ack(1'b1, 1, 10, cyc);
    chk("st_latency", cyc, 2);
    chk("st_mem_idle", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(posedge clk); #1;

    // ---- load back 0x1234 ----
    bus.d_req = 1'b1; bus.d_addr = 16'h1234;
    exp_d_q.push_back(8'hA5);
    wait_ack(1'b1, 0, 20, cyc);
    chk("ld_latency", cyc, 2 + LAT);
    bus.d_req = 1'b0;
    @(posedge clk); #1;

    // ---- fetch with address wrap ----
    poke(16'hFFFF, 8'h12);
    poke(16'h0000, 8'h34);
    addr_log.delete();
    bus.i_req = 1'b1; bus.i_addr = 16'hFFFF;
    exp_i_q.push_back(16'h1234);
    wait_ack(1'b0, 0, 40, cyc);
    chk("fw_latency", cyc, 3 + 2 * LAT);
    bus.i_req = 1'b0;
    chk("fw_nacc", addr_log.size(), 2);
    if (addr_log.size() >= 2) begin
      chk("fw_addr0", addr_log[0], 16'hFFFF);
      chk("fw_addr1", addr_log[1], 16'h0000);
    end
    @(posedge clk); #1;

    // ---- contention: load and fetch requested together ----
    poke(16'h0010, 8'h5C);
    poke(16'h0100, 8'hAB);
    poke(16'h0101, 8'hCD);
    exp_d_q.push_back(8'h5C);
    exp_i_q.push_back(16'hABCD);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0010;
    bus.i_req = 1'b1; bus.i_addr = 16'h0100;
    d_at = 0; i_at = 0; busy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      // Only the single IDLE cycle between the two accesses has busy low.
      if (bus.busy !== (c != 3 + LAT)) busy_bad++;
      if (bus.d_ack) begin d_at = c; bus.d_req = 1'b0; end
      if (bus.i_ack) begin i_at = c; bus.i_req = 1'b0; break; end
    end
    chk("ct_d_cycle", d_at, 2 + LAT);
    chk("ct_i_cycle", i_at, 6 + 3 * LAT);
    chk("ct_busy",    busy_bad, 0);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(posedge clk); #1;

    // ---- reset during the WAIT of a fetch ----
    bus.i_req = 1'b1; bus.i_addr = 16'h0100;
    @(posedge clk); #1;
    chk("rm_issue_en", bus.mem_en, 1);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("rm_busy",  bus.busy,   0);
    chk("rm_mem",   {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    chk("rm_acks",  {bus.i_ack, bus.d_ack}, 0);
    chk("rm_instr", bus.i_instr, 0);
    chk("rm_rdata", bus.d_rdata, 0);
    bus.i_req = 1'b0;
    @(posedge clk); #1;
    chk("rm_no_ack", bus.i_ack, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 16'h0100;
    exp_i_q.push_back(16'hABCD);
    wait_ack(1'b0, 0, 40, cyc);
    chk("rm_refetch_latency", cyc, 3 + 2 * LAT);
    bus.i_req = 1'b0;
    @(posedge clk); #1;

    // ---- starvation: data held continuously with fetch pending ----
    poke(16'h0020, 8'h77);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
    bus.i_req = 1'b1; bus.i_addr = 16'h0100;
    exp_d_q.push_back(8'h77);
    exp_i_q.push_back(16'hABCD);
    d_before = 0; d_total = 0; i_seen = 0; stop = 1'b0;
    for (int c = 1; c <= 150 && !stop; c++) begin
      @(posedge clk); #1;
      if (bus.i_ack) begin
        i_seen++;
        if (i_seen == 1) d_before = d_total;
        bus.i_req = 1'b0;
      end
      if (bus.d_ack) begin
        d_total++;
        if (c >= 60) begin
          bus.d_req = 1'b0;
          stop = 1'b1;
        end else begin
          exp_d_q.push_back(8'h77);  // held request is a fresh load
        end
      end
    end
    chk("sv_stopped", stop, 1);
`ifdef ARB_STARVE_GUARD_EN
    chk("sv_d_before_i", d_before, LIMIT);
    chk("sv_i_count",    i_seen,   1);
    chk("sv_d_resumed",  (d_total > d_before), 1);
`else
    chk("sv_i_count", i_seen, 0);
    chk("sv_d_count", (d_total >= 10), 1);
    // Fetch is granted in the IDLE cycle right after the final data ack.
    wait_ack(1'b0, 0, 40, cyc);
    chk("sv_i_after_release", cyc, 4 + 2 * LAT);
    bus.i_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("sb_d_empty", exp_d_q.size(), 0);
    chk("sb_i_empty", exp_i_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
